dp_ram_rd_stream: RTL and testbench



---
 rtl/dp_ram_rd_pkg.sv | 15 +
 rtl/dp_ram_rd_fifo.sv | 40 ++++
 rtl/dp_ram_rd_stream.sv | 129 ++++++++++++
 tb/tb_dp_ram_rd_stream.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dp_ram_rd_pkg.sv
// Shared definitions for the DP_RAM read streamer: FSM encoding, read latency
// and FIFO counter sizing.
package dp_ram_rd_pkg;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FIN} rd_state_t;

  localparam int C_RD_LAT     = 2;
  localparam int C_FIFO_D_DEF = 4;

  // Counter must represent 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/dp_ram_rd_fifo.sv
// Small synchronous FIFO for {LAST, DATA} beats; head word is read straight
// from the storage flops so a push becomes visible on the next cycle.
module dp_ram_rd_fifo #(
  parameter int W  = 73,
  parameter int D  = 4,
  parameter int CW = 3
) (
  input  logic          CK_i,
  input  logic          RST_i,
  input  logic          PUSH_i,
  input  logic [W-1:0]  WD_i,
  input  logic          POP_i,
  output logic [W-1:0]  RD_o,
  output logic [CW-1:0] CNT_o
);

  localparam int PW = (D > 1) ? $clog2(D) : 1;

  logic [W-1:0]  mem [D];
  logic [PW-1:0] wp, rp;

  assign RD_o = mem[rp];

  always_ff @(posedge CK_i) begin
    if (RST_i) begin
      wp    <= '0;
      rp    <= '0;
      CNT_o <= '0;
      for (int i = 0; i < D; i++) mem[i] <= '0;
    end else begin
      if (PUSH_i) begin
        mem[wp] <= WD_i;
        wp      <= (wp == PW'(D - 1)) ? '0 : wp + PW'(1);
      end
      if (POP_i) rp <= (rp == PW'(D - 1)) ? '0 : rp + PW'(1);
      CNT_o <= CNT_o + CW'(PUSH_i) - CW'(POP_i);
    end
  end

endmodule

// File: rtl/dp_ram_rd_stream.sv
// DP_RAM read streamer: walks an address block, hides the fixed RAM read latency
// and emits a valid/ready stream. `DP_RAM_RD_STREAM_STALL_CNT_EN adds STALL_CNT_o.
module dp_ram_rd_stream
  import dp_ram_rd_pkg::*;
#(
  parameter int C_DAT_W  = 72,
  parameter int C_ADR_W  = 10,
  parameter int C_LEN_W  = 11,
  parameter int C_FIFO_D = C_FIFO_D_DEF
) (
  input  logic               CK_i,
  input  logic               RST_i,
  input  logic               START_i,
  input  logic [C_ADR_W-1:0] BASE_A_i,
  input  logic [C_LEN_W-1:0] LEN_i,
  output logic               BUSY_o,
  output logic               DONE_o,
  output logic [C_ADR_W-1:0] RA_o,
  input  logic [C_DAT_W-1:0] RD_i,
  output logic [C_DAT_W-1:0] DAT_o,
  output logic               VLD_o,
  input  logic               RDY_i,
`ifdef DP_RAM_RD_STREAM_STALL_CNT_EN
  output logic [15:0]        STALL_CNT_o,
`endif
  output logic               LAST_o
);

  localparam int CW = cnt_w(C_FIFO_D);

  rd_state_t          st;
  logic [C_LEN_W-1:0] rem;
  logic [C_RD_LAT:0]  vld_pipe, lst_pipe;
  logic [CW-1:0]      fcnt;
  logic [C_DAT_W:0]   head;
  logic               start_ok, iss_nxt, iss_in, iss_last, pop;
  int                 pend;

  assign VLD_o  = (fcnt != '0);
  assign DAT_o  = head[C_DAT_W-1:0];
  assign LAST_o = VLD_o & head[C_DAT_W];
  assign pop    = VLD_o & RDY_i;

  // Credit counts the beat leaving this cycle, so a full pipe still issues
  // every cycle while the consumer keeps up.
  always_comb begin
    start_ok = (st == S_IDLE) && START_i;
    pend     = int'(fcnt) + $countones(vld_pipe) - int'(pop);
    iss_nxt  = (st == S_RUN) && (rem != '0) && (pend < C_FIFO_D);
    iss_in   = start_ok ? (LEN_i != '0) : iss_nxt;
    iss_last = start_ok ? (LEN_i == C_LEN_W'(1)) : (rem == C_LEN_W'(1));
  end

  // vld_pipe[0] marks the cycle RA_o carries a fresh address; the top stage
  // lines up with RD_i and pushes it.
  always_ff @(posedge CK_i) begin
    if (RST_i) begin
      st       <= S_IDLE;
      rem      <= '0;
      RA_o     <= '0;
      BUSY_o   <= 1'b0;
      DONE_o   <= 1'b0;
      vld_pipe <= '0;
      lst_pipe <= '0;
    end else begin
      vld_pipe <= {vld_pipe[C_RD_LAT-1:0], iss_in};
      lst_pipe <= {lst_pipe[C_RD_LAT-1:0], iss_in & iss_last};
      case (st)
        S_IDLE: if (START_i) begin
          BUSY_o <= 1'b1;
          rem    <= '0;
          st     <= S_FIN;
          if (LEN_i != '0) begin
            RA_o <= BASE_A_i;
            rem  <= LEN_i - C_LEN_W'(1);
            st   <= S_RUN;
          end
        end
        S_RUN: begin
          if (iss_nxt) begin
            RA_o <= RA_o + C_ADR_W'(1);
            rem  <= rem - C_LEN_W'(1);
            if (rem == C_LEN_W'(1)) st <= S_DRAIN;
          end else if (rem == '0) begin
            st <= S_DRAIN;
          end
        end
        S_DRAIN: if (pop && LAST_o) begin
          st     <= S_FIN;
          BUSY_o <= 1'b0;
          DONE_o <= 1'b1;
        end
        // Zero-length bursts arrive here with DONE low and pulse one cycle later.
        S_FIN: begin
          if (DONE_o) begin
            st     <= S_IDLE;
            DONE_o <= 1'b0;
          end else begin
            BUSY_o <= 1'b0;
            DONE_o <= 1'b1;
          end
        end
        default: st <= S_IDLE;
      endcase
    end
  end

  dp_ram_rd_fifo #(
    .W  (C_DAT_W + 1),
    .D  (C_FIFO_D),
    .CW (CW)
  ) u_fifo (
    .CK_i   (CK_i),
    .RST_i  (RST_i),
    .PUSH_i (vld_pipe[C_RD_LAT]),
    .WD_i   ({lst_pipe[C_RD_LAT], RD_i}),
    .POP_i  (pop),
    .RD_o   (head),
    .CNT_o  (fcnt)
  );

`ifdef DP_RAM_RD_STREAM_STALL_CNT_EN
  always_ff @(posedge CK_i) begin
    if (RST_i || start_ok)                            STALL_CNT_o <= '0;
    else if (VLD_o && !RDY_i && STALL_CNT_o != '1)    STALL_CNT_o <= STALL_CNT_o + 16'd1;
  end
`endif

endmodule

// File: tb/tb_dp_ram_rd_stream.sv
// Bench for dp_ram_rd_stream: behavioural 2-cycle RAM, expected-beat queue
// built from address arithmetic, directed and randomised bursts.
module tb_dp_ram_rd_stream;

  localparam int DW = 72, AW = 10, LW = 11, NW = 1 << AW;

  logic          CK_i = 1'b0;
  logic          RST_i, START_i, RDY_i;
  logic [AW-1:0] BASE_A_i, RA_o;
  logic [LW-1:0] LEN_i;
  logic          BUSY_o, DONE_o, VLD_o, LAST_o;
  logic [DW-1:0] RD_i, DAT_o;
`ifdef DP_RAM_RD_STREAM_STALL_CNT_EN
  logic [15:0]   STALL_CNT_o;
`endif

  dp_ram_rd_stream dut (
    .CK_i     (CK_i),
    .RST_i    (RST_i),
    .START_i  (START_i),
    .BASE_A_i (BASE_A_i),
    .LEN_i    (LEN_i),
    .BUSY_o   (BUSY_o),
    .DONE_o   (DONE_o),
    .RA_o     (RA_o),
    .RD_i     (RD_i),
    .DAT_o    (DAT_o),
    .VLD_o    (VLD_o),
    .RDY_i    (RDY_i),
`ifdef DP_RAM_RD_STREAM_STALL_CNT_EN
    .STALL_CNT_o (STALL_CNT_o),
`endif
    .LAST_o   (LAST_o)
  );

  always #5 CK_i = ~CK_i;

  // RAM: address registered, then data registered -> RD_i valid 2 cycles after RA_o.
  logic [DW-1:0] mem [NW];
  logic [AW-1:0] ra_d;
  always @(posedge CK_i) begin
    ra_d <= RA_o;
    RD_i <= mem[ra_d];
  end

  typedef struct packed { logic [DW-1:0] d; logic l; } beat_t;
  beat_t exp_q[$];
  int    ra_log[$];
  int    ntot = 0, npass = 0, cyc = 0, sc = 0;
  int    first_vld, last_acc, done_cyc, ndone, nbeats, nvld, ra_last;
  logic          stl_prev = 1'b0, plast;
  logic [DW-1:0] pdat;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: got %0d want %0d", tag, obs, exp);
  endtask

  task automatic mon();
    beat_t e;
    if (stl_prev) begin
      chki("stable_vld", int'(VLD_o), 1);
      chk("stable_dat", DAT_o, pdat);
      chki("stable_last", int'(LAST_o), int'(plast));
    end
    if (VLD_o) nvld++;
    if (VLD_o && first_vld < 0) first_vld = cyc;
    if (VLD_o && RDY_i) begin
      if (exp_q.size() == 0) chki("extra_beat", int'(VLD_o), 0);
      else begin
        e = exp_q.pop_front();
        chk("dat", DAT_o, e.d);
        chki("last", int'(LAST_o), int'(e.l));
        nbeats++;
        last_acc = cyc;
      end
    end
    if (DONE_o) begin
      ndone++;
      done_cyc = cyc;
    end
    if (int'(RA_o) != ra_last) begin
      ra_log.push_back(int'(RA_o));
      ra_last = int'(RA_o);
    end
    stl_prev = VLD_o && !RDY_i;
    pdat     = DAT_o;
    plast    = LAST_o;
  endtask

  // Sample mid-cycle, then advance to just after the next rising edge.
  task automatic step();
    @(negedge CK_i);
    if (RST_i) stl_prev = 1'b0;
    else mon();
    @(posedge CK_i);
    cyc++;
    #1;
  endtask

  function automatic logic rdy_pat(input int mode, input int c);
    case (mode)
      0:       return 1'b1;
      1:       return (c % 4) == 0;
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  task automatic arm(input int base, input int len);
    beat_t b;
    exp_q.delete();
    ra_log.delete();
    ra_last   = int'(RA_o);
    first_vld = -1; last_acc = -1; done_cyc = -1;
    ndone = 0; nbeats = 0; nvld = 0;
    for (int k = 0; k < len; k++) begin
      b.d = mem[(base + k) % NW];
      b.l = (k == len - 1);
      exp_q.push_back(b);
    end
    BASE_A_i = AW'(base);
    LEN_i    = LW'(len);
  endtask

  task automatic burst(input int base, input int len, input int mode, input bit restart);
    arm(base, len);
    START_i = 1'b1;
    RDY_i   = rdy_pat(mode, 0);
    sc      = cyc;
    step();
    START_i = 1'b0;
    chki("busy_on", int'(BUSY_o), 1);
    for (int c = 1; c < 6 * len + 40 && ndone == 0; c++) begin
      if (restart) begin
        START_i = (c <= 2);
        LEN_i   = LW'(5);
      end
      RDY_i = rdy_pat(mode, c);
      step();
    end
    START_i = 1'b0;
    chki("done_seen", ndone, 1);
    chki("all_beats", exp_q.size(), 0);
    RDY_i = 1'b1;
    repeat (6) step();
    chki("done_once", ndone, 1);
    chki("busy_off", int'(BUSY_o), 0);
  endtask

  task automatic chk_reset();
    chki("rst_busy", int'(BUSY_o), 0);
    chki("rst_done", int'(DONE_o), 0);
    chki("rst_ra", int'(RA_o), 0);
    chk("rst_dat", DAT_o, '0);
    chki("rst_vld", int'(VLD_o), 0);
    chki("rst_last", int'(LAST_o), 0);
  endtask

  initial begin
    for (int i = 0; i < NW; i++) mem[i] = DW'(i);
    RST_i = 1'b1; START_i = 1'b0; RDY_i = 1'b0; BASE_A_i = '0; LEN_i = '0;
    repeat (3) step();
    chk_reset();
    RST_i = 1'b0;
    step();

    // Basic burst: latency, back-to-back throughput, LAST and DONE timing.
    burst('h010, 8, 0, 1'b0);
    chki("t1_first_vld_lat", first_vld - sc, 4);
    chki("t1_back_to_back", last_acc - first_vld, 7);
    chki("t1_done_after_last", done_cyc - last_acc, 1);

    // Address wrap at the top of RAM.
    burst('h3FE, 4, 0, 1'b0);
    chki("t2_ra_count", ra_log.size(), 4);
    for (int k = 0; k < 4 && k < ra_log.size(); k++)
      chki("t2_ra_seq", ra_log[k], ('h3FE + k) % NW);

    // Heavy backpressure: 1 cycle ready, 3 cycles stalled.
    burst('h050, 16, 1, 1'b0);
    chki("t3_beats", nbeats, 16);

    // Zero length, with START retried while busy and on the DONE cycle.
    burst('h123, 0, 0, 1'b1);
    chki("t4_ra_still", ra_log.size(), 0);
    chki("t4_no_vld", nvld, 0);
    chki("t4_done_lat", done_cyc - sc, 2);

    burst('h200, 1, 0, 1'b0);
    chki("t5_len1_beats", nbeats, 1);

    // Reset in the middle of a 12-word burst.
    arm('h040, 12);
    START_i = 1'b1; RDY_i = 1'b1;
    step();
    START_i = 1'b0;
    for (int c = 0; c < 60 && nbeats < 5; c++) step();
    chki("t6_pre_rst_beats", nbeats, 5);
    RST_i = 1'b1;
    step();
    chk_reset();
    RST_i = 1'b0;
    exp_q.delete(); ndone = 0; nvld = 0;
    repeat (8) step();
    chki("t6_no_done", ndone, 0);
    chki("t6_no_vld", nvld, 0);
    burst('h100, 3, 0, 1'b0);
    chki("t6_after_beats", nbeats, 3);

    // Randomised bursts, then a full-RAM sweep from a random base.
    for (int t = 0; t < 6; t++)
      burst(int'($urandom_range(0, NW - 1)), int'($urandom_range(1, 40)), 2, 1'b0);
    burst(int'($urandom_range(0, NW - 1)), NW, 2, 1'b0);
    chki("t7_full_beats", nbeats, NW);

`ifdef DP_RAM_RD_STREAM_STALL_CNT_EN
    arm('h020, 4);
    START_i = 1'b1; RDY_i = 1'b0;
    step();
    START_i = 1'b0;
    chki("stall_clr", int'(STALL_CNT_o), 0);
    for (int c = 0; c < 20 && !VLD_o; c++) step();
    chki("stall_vld_up", int'(VLD_o), 1);
    repeat (10) step();
    chki("stall_cnt", int'(STALL_CNT_o), 10);
    RDY_i = 1'b1;
    for (int c = 0; c < 40 && ndone == 0; c++) step();
    chki("stall_done", ndone, 1);
    chki("stall_beats", nbeats, 4);
`endif

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
